// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the port-0 SRAM arbiter slice.
// The option SRAM_ARB_RR_EN is consumed by sram_rr_arbiter, not here.
package sram_ctrl_pkg;

    localparam int SRAM_ADDR_WIDTH = 9;
    localparam int SRAM_DATA_WIDTH = 32;
    localparam int SRAM_NUM_WMASKS = 4;
    localparam int SRAM_RD_LATENCY = 2;

    typedef enum logic {
        ID_M0 = 1'b0,
        ID_M1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                       we;
        logic [SRAM_NUM_WMASKS-1:0] wmask;
        logic [SRAM_ADDR_WIDTH-1:0] addr;
        logic [SRAM_DATA_WIDTH-1:0] wdata;
    } sram_req_t;

    function automatic req_id_t other_id(input req_id_t id);
        return (id == ID_M0) ? ID_M1 : ID_M0;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way grant logic for the shared SRAM port. With SRAM_ARB_RR_EN defined a
// round-robin pointer settles contention; otherwise m0 has fixed priority.
module sram_rr_arbiter
    import sram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    req_id_t winner;

`ifdef SRAM_ARB_RR_EN
    req_id_t ptr_q;
    req_id_t ptr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= ID_M0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // The pointer only moves on contention, handing priority to the loser.
    always_comb begin
        winner = ID_M0;
        ptr_d  = ptr_q;
        if (valid0 && valid1) begin
            winner = ptr_q;
            ptr_d  = other_id(ptr_q);
        end else if (valid1) begin
            winner = ID_M1;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    always_comb begin
        winner = ID_M0;
        if (!valid0 && valid1) begin
            winner = ID_M1;
        end
    end
`endif

    assign grant0 = valid0 && (winner == ID_M0);
    assign grant1 = valid1 && (winner == ID_M1);

endmodule

// File: rtl/sram_port0_arbiter.sv
// Shares port 0 of the 32x512 SRAM wrapper between two requesters with a fixed
// two-cycle response latency. Arbitration mode is selected by SRAM_ARB_RR_EN.
module sram_port0_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int NUM_WMASKS = SRAM_NUM_WMASKS
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [NUM_WMASKS-1:0] m0_req_wmask,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_rdata,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [NUM_WMASKS-1:0] m1_req_wmask,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_rdata,

    output logic                  sram_cs0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    // Handshake: a request transfers in the cycle where valid and ready are
    // both high; ready is the grant, so it never rises without valid.
    sram_req_t req0;
    sram_req_t req1;
    sram_req_t win_req;
    logic      grant0;
    logic      grant1;
    logic      issue;
    req_id_t   issue_id;

    assign req0 = '{we: m0_req_we, wmask: m0_req_wmask, addr: m0_req_addr, wdata: m0_req_wdata};
    assign req1 = '{we: m1_req_we, wmask: m1_req_wmask, addr: m1_req_addr, wdata: m1_req_wdata};

    sram_rr_arbiter u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (m0_req_valid),
        .valid1 (m1_req_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign m0_req_ready = grant0;
    assign m1_req_ready = grant1;
    assign issue        = grant0 | grant1;
    assign issue_id     = grant1 ? ID_M1 : ID_M0;

    // An all-zero request on idle cycles parks the pins at their quiet values.
    always_comb begin
        win_req = '0;
        if (grant0) begin
            win_req = req0;
        end else if (grant1) begin
            win_req = req1;
        end
    end

    assign sram_cs0    = issue;
    assign sram_web0   = ~(issue & win_req.we);
    assign sram_wmask0 = win_req.wmask;
    assign sram_addr0  = win_req.addr;
    assign sram_din0   = win_req.wdata;

    logic    s1_valid;
    req_id_t s1_id;
    logic    s1_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_id    <= ID_M0;
            s1_we    <= 1'b0;
        end else begin
            s1_valid <= issue;
            s1_id    <= issue_id;
            s1_we    <= win_req.we;
        end
    end

    // dout0 is stable by the end of stage 1, so it is captured straight into
    // the response register of the owning requester; rdata holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rsp_valid <= 1'b0;
            m0_rsp_rdata <= '0;
            m1_rsp_valid <= 1'b0;
            m1_rsp_rdata <= '0;
        end else begin
            m0_rsp_valid <= s1_valid && (s1_id == ID_M0);
            m1_rsp_valid <= s1_valid && (s1_id == ID_M1);
            if (s1_valid && (s1_id == ID_M0)) begin
                m0_rsp_rdata <= s1_we ? '0 : sram_dout0;
            end
            if (s1_valid && (s1_id == ID_M1)) begin
                m1_rsp_rdata <= s1_we ? '0 : sram_dout0;
            end
        end
    end

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Self-checking bench for sram_port0_arbiter with a behavioural SRAM macro and
// a transaction-level reference model. Honours SRAM_ARB_RR_EN when defined.
module tb_sram_port0_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
    logic [3:0]  m0_req_wmask;
    logic [8:0]  m0_req_addr;
    logic [31:0] m0_req_wdata, m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
    logic [3:0]  m1_req_wmask;
    logic [8:0]  m1_req_addr;
    logic [31:0] m1_req_wdata, m1_rsp_rdata;
    logic        sram_cs0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0;
    logic [31:0] sram_din0, sram_dout0;

    sram_port0_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_we    (m0_req_we),
        .m0_req_wmask (m0_req_wmask),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_we    (m1_req_we),
        .m1_req_wmask (m1_req_wmask),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_rdata (m1_rsp_rdata),
        .sram_cs0     (sram_cs0),
        .sram_web0    (sram_web0),
        .sram_wmask0  (sram_wmask0),
        .sram_addr0   (sram_addr0),
        .sram_din0    (sram_din0),
        .sram_dout0   (sram_dout0)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [31:0] init_val(input int a);
        return 32'h9E37_79B9 * (a + 1);
    endfunction

    function automatic logic [31:0] apply_mask(input logic [31:0] old_w, input logic [31:0] data,
                                               input logic [3:0] mask);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    // ---------------- behavioural SRAM macro ----------------
    logic [31:0] sram_mem [512];
    bit          sram_written [512];
    logic        lat_v, lat_web;
    logic [3:0]  lat_mask;
    logic [8:0]  lat_addr;
    logic [31:0] lat_din;

    always @(posedge clk) begin
        lat_v    <= sram_cs0;
        lat_web  <= sram_web0;
        lat_mask <= sram_wmask0;
        lat_addr <= sram_addr0;
        lat_din  <= sram_din0;
    end

    always @(negedge clk) begin
        if (lat_v === 1'b1) begin
            if (lat_web == 1'b0) begin
                sram_mem[lat_addr] <= apply_mask(sram_written[lat_addr] ? sram_mem[lat_addr]
                                                 : init_val(int'(lat_addr)), lat_din, lat_mask);
                sram_written[lat_addr] <= 1'b1;
            end else begin
                sram_dout0 <= sram_written[lat_addr] ? sram_mem[lat_addr] : init_val(int'(lat_addr));
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [512];
    logic [31:0] last_rdata [2];
    int          cycle;
    int          checks;
    int          errors;
`ifdef SRAM_ARB_RR_EN
    int          rr_next;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_m0(input logic v, input logic we, input logic [3:0] mask,
                          input logic [8:0] addr, input logic [31:0] data);
        m0_req_valid = v; m0_req_we = we; m0_req_wmask = mask;
        m0_req_addr = addr; m0_req_wdata = data;
    endtask

    task automatic set_m1(input logic v, input logic we, input logic [3:0] mask,
                          input logic [8:0] addr, input logic [31:0] data);
        m1_req_valid = v; m1_req_we = we; m1_req_wmask = mask;
        m1_req_addr = addr; m1_req_wdata = data;
    endtask

    task automatic idle();
        set_m0(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
        set_m1(1'b0, 1'b0, 4'h0, 9'h0, 32'h0);
    endtask

    task automatic check_rsp();
        logic v [2];
        exp_t e;
        v[0] = 1'b0;
        v[1] = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cycle) begin
            e = exp_q.pop_front();
            v[e.id] = 1'b1;
            last_rdata[e.id] = e.data;
        end
        chk("m0_rsp_valid", m0_rsp_valid, v[0]);
        chk("m0_rsp_rdata", m0_rsp_rdata, last_rdata[0]);
        chk("m1_rsp_valid", m1_rsp_valid, v[1]);
        chk("m1_rsp_rdata", m1_rsp_rdata, last_rdata[1]);
    endtask

    // One issue cycle: inputs are already applied at posedge+1.
    task automatic tick();
        int          win;
        logic        we;
        logic [3:0]  mask;
        logic [8:0]  addr;
        logic [31:0] data;
        exp_t        e;
        win = -1;
        if (m0_req_valid && m1_req_valid) begin
`ifdef SRAM_ARB_RR_EN
            win = rr_next;
            rr_next = 1 - rr_next;
`else
            win = 0;
`endif
        end else if (m0_req_valid) begin
            win = 0;
        end else if (m1_req_valid) begin
            win = 1;
        end
        #2;
        chk("m0_req_ready", m0_req_ready, win == 0);
        chk("m1_req_ready", m1_req_ready, win == 1);
        if (win < 0) begin
            chk("idle_cs0", sram_cs0, 0);
            chk("idle_web0", sram_web0, 1);
            chk("idle_wmask0", sram_wmask0, 0);
            chk("idle_addr0", sram_addr0, 0);
            chk("idle_din0", sram_din0, 0);
        end else begin
            we   = (win == 1) ? m1_req_we    : m0_req_we;
            mask = (win == 1) ? m1_req_wmask : m0_req_wmask;
            addr = (win == 1) ? m1_req_addr  : m0_req_addr;
            data = (win == 1) ? m1_req_wdata : m0_req_wdata;
            chk("cs0", sram_cs0, 1);
            chk("web0", sram_web0, !we);
            chk("wmask0", sram_wmask0, mask);
            chk("addr0", sram_addr0, addr);
            chk("din0", sram_din0, data);
            e.due = cycle + 2;
            e.id  = win;
            if (we) begin
                ref_mem[addr] = apply_mask(ref_mem[addr], data, mask);
                e.data = 32'h0;
            end else begin
                e.data = ref_mem[addr];
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cycle++;
        check_rsp();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        last_rdata[0] = 32'h0;
        last_rdata[1] = 32'h0;
`ifdef SRAM_ARB_RR_EN
        rr_next = 0;
`endif
        for (int a = 0; a < 512; a++) ref_mem[a] = init_val(a);
        rst_n = 1'b0;
        idle();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_m0_rsp_valid", m0_rsp_valid, 0);
        chk("rst_m0_rsp_rdata", m0_rsp_rdata, 0);
        chk("rst_m1_rsp_valid", m1_rsp_valid, 0);
        chk("rst_m1_rsp_rdata", m1_rsp_rdata, 0);
        chk("rst_cs0", sram_cs0, 0);
        rst_n = 1'b1;

        // idle cycles
        tick();
        tick();

        // write then read of the same address on consecutive cycles
        set_m0(1'b1, 1'b1, 4'hF, 9'h005, 32'hDEAD_BEEF);
        tick();
        set_m0(1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
        tick();
        idle();
        tick();
        tick();
        chk("wr_rd_same_addr", m0_rsp_rdata, 32'hDEAD_BEEF);

        // partial byte-lane write on m1 at the top address
        set_m1(1'b1, 1'b1, 4'hF, 9'h1FF, 32'hAABB_CCDD);
        tick();
        set_m1(1'b1, 1'b1, 4'b0101, 9'h1FF, 32'h1122_3344);
        tick();
        set_m1(1'b1, 1'b0, 4'h0, 9'h1FF, 32'h0);
        tick();
        idle();
        tick();
        tick();
        chk("partial_wmask", m1_rsp_rdata, 32'hAA22_CC44);

        // wmask = 0 write leaves memory untouched
        set_m0(1'b1, 1'b1, 4'h0, 9'h005, 32'h1234_5678);
        tick();
        set_m0(1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
        tick();
        idle();
        tick();
        tick();
        chk("zero_wmask", m0_rsp_rdata, 32'hDEAD_BEEF);

        // four cycles of contention, all reads
        for (int i = 0; i < 4; i++) begin
            set_m0(1'b1, 1'b0, 4'h0, 9'(16 + i), 32'h0);
            set_m1(1'b1, 1'b0, 4'h0, 9'(32 + i), 32'h0);
            tick();
        end
        idle();
        tick();
        tick();

        // eight back-to-back reads
        for (int i = 0; i < 8; i++) begin
            set_m0(1'b1, 1'b0, 4'h0, 9'(i), 32'h0);
            tick();
        end
        idle();
        tick();
        tick();

        // reset pulse while a read is in flight
        set_m0(1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
        tick();
        idle();
        rst_n = 1'b0;
        exp_q.delete();
        last_rdata[0] = 32'h0;
        last_rdata[1] = 32'h0;
`ifdef SRAM_ARB_RR_EN
        rr_next = 0;
`endif
        #1;
        chk("midrst_rsp_valid", m0_rsp_valid, 0);
        chk("midrst_rsp_rdata", m0_rsp_rdata, 0);
        @(posedge clk);
        #1;
        cycle++;
        chk("midrst_no_rsp", m0_rsp_valid, 0);
        rst_n = 1'b1;
        tick();
        tick();
        set_m0(1'b1, 1'b0, 4'h0, 9'h005, 32'h0);
        tick();
        idle();
        tick();
        tick();
        chk("post_rst_read", m0_rsp_rdata, 32'hDEAD_BEEF);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15)),
                   $urandom);
            set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 15)),
                   $urandom);
            tick();
        end
        idle();
        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
